// File: rtl/video_capture.sv
// Video capture front end: measures line/frame timing from the syncs, locks onto
// stable timing and emits a registered pixel write stream for the visible area.
module video_capture #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        sync_h,
    input  logic        sync_v,
    input  logic        blank,
    input  logic [4:0]  r,
    input  logic [4:0]  g,
    input  logic [4:0]  b,
    output logic        pix_we,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [14:0] pix_rgb,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        pal_detect,
    output logic        locked,
    output logic        frame_start
);
    localparam int            LW       = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);
    localparam logic [LW-1:0] LOCK_ONE = LW'(1);

    logic          h_prev, v_prev, blank_prev, v_seen;
    logic [9:0]    h_cnt, v_cnt;
    logic [8:0]    x_cnt;
    logic [7:0]    y_cnt;
    logic [LW-1:0] lock_cnt;

    logic       h_rise, v_rise, b_rise, b_fall, fl_load, x_past;
    logic       lock_clr, lock_inc, wr;
    logic [9:0] h_nxt, v_nxt, len_new, fl_new;
    logic [8:0] x_nxt;
    logic [7:0] y_nxt;

    // Next-state values for the current sample; only committed when ce=1.
    always_comb begin
        h_rise   = sync_h & ~h_prev;
        v_rise   = sync_v & ~v_prev;
        b_rise   = blank & ~blank_prev;
        b_fall   = ~blank & blank_prev;
        h_nxt    = h_rise ? 10'd0 : ((&h_cnt) ? h_cnt : h_cnt + 10'd1);
        len_new  = h_cnt + 10'd1;
        v_nxt    = v_rise ? 10'd0 : ((h_rise && !(&v_cnt)) ? v_cnt + 10'd1 : v_cnt);
        fl_new   = v_cnt + 10'd1;
        fl_load  = v_rise & v_seen;
        x_nxt    = b_fall ? 9'd0 : ((!blank && !(&x_cnt)) ? x_cnt + 9'd1 : x_cnt);
        // x_cnt already at 511 before this sample means the pixel lies beyond x=511
        x_past   = !b_fall && (&x_cnt);
        y_nxt    = v_rise ? 8'd0 : ((b_rise && !(&y_cnt)) ? y_cnt + 8'd1 : y_cnt);
        lock_clr = (fl_load && fl_new != frame_lines) ||
                   (h_rise && len_new != line_len) || (&h_nxt);
        lock_inc = fl_load && fl_new == frame_lines && lock_cnt != LOCK_MAX;
        wr       = ~blank & locked & (y_nxt < 8'd240) & ~x_past;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_prev      <= 1'b0;
            v_prev      <= 1'b0;
            blank_prev  <= 1'b0;
            v_seen      <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            lock_cnt    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            pal_detect  <= 1'b0;
            frame_start <= 1'b0;
            pix_we      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
        end else begin
            pix_we      <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                h_prev      <= sync_h;
                v_prev      <= sync_v;
                blank_prev  <= blank;
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                x_cnt       <= x_nxt;
                y_cnt       <= y_nxt;
                frame_start <= v_rise;
                if (h_rise) line_len <= len_new;
                if (v_rise) v_seen <= 1'b1;
                if (fl_load) begin
                    frame_lines <= fl_new;
                    if (fl_new >= 10'd300 && fl_new <= 10'd320)
                        pal_detect <= 1'b1;
                    else if (fl_new >= 10'd252 && fl_new <= 10'd272)
                        pal_detect <= 1'b0;
                end
                if (lock_clr)
                    lock_cnt <= '0;
                else if (lock_inc)
                    lock_cnt <= lock_cnt + LOCK_ONE;
                if (wr) begin
                    pix_we  <= 1'b1;
                    pix_x   <= x_nxt;
                    pix_y   <= y_nxt;
                    pix_rgb <= {b, g, r};
                end
            end
        end
    end

    assign locked = (lock_cnt == LOCK_MAX);
endmodule

// File: tb/tb_video_capture.sv
// Directed frame sequences with random ce gaps and random colours, checked against
// a frame-level reference model of timing measurement, lock and pixel writes.
module tb_video_capture;
    localparam int LF = 2;

    logic        clk = 0, reset_n = 1, ce = 0, sync_h = 0, sync_v = 0, blank = 1;
    logic [4:0]  r = 0, g = 0, b = 0;
    logic        pix_we, pal_detect, locked, frame_start;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [14:0] pix_rgb;
    logic [9:0]  line_len, frame_lines;

    video_capture #(.LOCK_FRAMES(LF)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .sync_h(sync_h), .sync_v(sync_v),
        .blank(blank), .r(r), .g(g), .b(b), .pix_we(pix_we), .pix_x(pix_x),
        .pix_y(pix_y), .pix_rgb(pix_rgb), .line_len(line_len),
        .frame_lines(frame_lines), .pal_detect(pal_detect), .locked(locked),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // reference model state
    bit p_h, p_v, m_seen, m_pal, m_lk;
    int m_h, m_v, m_len, since;
    int hist[$];
    int lx, ly, lrgb;          // last expected write, for hold checks
    int wcount, ox, oy, fx, fy; // observed write count / last / first position

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p_h = 0; p_v = 0; m_seen = 0; m_pal = 0; m_lk = 0;
        m_h = 0; m_v = 0; m_len = 0; since = 0;
        hist.delete(); hist.push_back(0);
        lx = 0; ly = 0; lrgb = 0;
    endtask

    // Locked when the last LF+1 frame_lines values agree and at least LF of
    // those loads came after the most recent timing disturbance.
    function automatic bit lock_exp();
        int n = hist.size();
        if (since < LF || n < LF + 1) return 0;
        for (int i = n - LF; i < n; i++)
            if (hist[i] != hist[n-LF-1]) return 0;
        return 1;
    endfunction

    task automatic rst_checks(input string p);
        chk({p, "_we"}, pix_we, 0);
        chk({p, "_x"}, pix_x, 0);
        chk({p, "_y"}, pix_y, 0);
        chk({p, "_rgb"}, pix_rgb, 0);
        chk({p, "_line_len"}, line_len, 0);
        chk({p, "_frame_lines"}, frame_lines, 0);
        chk({p, "_pal"}, pal_detect, 0);
        chk({p, "_locked"}, locked, 0);
        chk({p, "_fs"}, frame_start, 0);
    endtask

    task automatic do_reset();
        #2 reset_n = 0; ce = 1;
        #1 rst_checks("midrst");
        model_reset();
        @(posedge clk); #1;
        ce = 0;
        chk("midrst_held_len", line_len, 0);
        reset_n = 1;
    endtask

    // ce=0 clock with scrambled inputs: nothing may change
    task automatic idle();
        ce = 0;
        {sync_h, sync_v, blank} = 3'($urandom);
        {b, g, r} = 15'($urandom);
        @(posedge clk); #1;
        chk("idle_we", pix_we, 0);
        chk("idle_fs", frame_start, 0);
        chk("idle_locked", locked, m_lk);
        chk("hold_x", pix_x, lx);
        chk("hold_y", pix_y, ly);
        chk("hold_rgb", pix_rgb, lrgb);
    endtask

    task automatic sample(input bit sh, input bit sv, input bit bl, input int px, input int py);
        bit hr, vr, ew;
        logic [14:0] rgb;
        int len, fl;
        while ($urandom_range(7, 0) == 0) idle();
        ce = 1; sync_h = sh; sync_v = sv; blank = bl;
        rgb = 15'($urandom);
        {b, g, r} = rgb;
        hr = sh && !p_h; vr = sv && !p_v; p_h = sh; p_v = sv;
        ew = !bl && m_lk && px < 512 && py < 240;
        @(posedge clk); #1;
        ce = 0;
        chk("pix_we", pix_we, ew);
        chk("frame_start", frame_start, vr);
        if (pix_we) begin
            if (wcount == 0) begin fx = pix_x; fy = pix_y; end
            wcount++; ox = pix_x; oy = pix_y;
        end
        if (ew) begin
            chk("pix_x", pix_x, px);
            chk("pix_y", pix_y, py);
            chk("pix_rgb", pix_rgb, rgb);
            lx = px; ly = py; lrgb = rgb;
        end
        if (vr) begin
            if (m_seen) begin
                fl = (m_v + 1) % 1024;
                hist.push_back(fl); since++;
                if (fl >= 300 && fl <= 320) m_pal = 1;
                else if (fl >= 252 && fl <= 272) m_pal = 0;
                chk("frame_lines", frame_lines, fl);
                chk("pal_detect", pal_detect, m_pal);
            end
            m_seen = 1; m_v = 0;
        end else if (hr && m_v < 1023) m_v++;
        if (hr) begin
            len = (m_h + 1) % 1024;
            if (len != m_len) since = 0;
            m_len = len; m_h = 0;
            chk("line_len", line_len, len);
        end else begin
            if (m_h < 1023) m_h++;
            if (m_h == 1023) since = 0;
        end
        m_lk = lock_exp();
        chk("locked", locked, m_lk);
    endtask

    // One frame: hl samples/line, nl lines, visible lines vl0.., visible samples x0..;
    // line sln shortened to slen; reset pulsed mid-line rln.
    task automatic frame(input int hl, input int nl, input int vl0, input int vln,
                         input int x0, input int xn, input int sln, input int slen,
                         input int rln);
        for (int ln = 0; ln < nl; ln++) begin
            int len;
            len = (ln == sln) ? slen : hl;
            for (int s = 0; s < len; s++) begin
                bit vis;
                vis = ln >= vl0 && ln < vl0 + vln && s >= x0 && s < x0 + xn;
                if (ln == rln && s == len / 2) do_reset();
                sample(s < 4, ln == 0 && s < 8, !vis, s - x0, ln - vl0);
            end
        end
    endtask

    initial begin
        model_reset();
        wcount = 0; ox = 0; oy = 0; fx = 0; fy = 0;
        #1 reset_n = 0;
        #2 rst_checks("reset");
        @(posedge clk); #1 reset_n = 1;

        // short-line NTSC/PAL frame counts
        for (int f = 0; f < 3; f++) frame(16, 262, 5, 250, 6, 8, -1, 0, -1);
        wcount = 0;
        frame(16, 312, 5, 250, 6, 8, -1, 0, -1);
        chk("ntsc_locked", locked, 1);
        chk("ntsc_frame_lines", frame_lines, 262);
        chk("ntsc_pal", pal_detect, 0);
        chk("ntsc_line_len", line_len, 16);
        chk("ntsc_writes", wcount, 240 * 8);
        chk("ntsc_last_y", oy, 239);
        chk("ntsc_last_x", ox, 7);
        frame(16, 262, 5, 250, 6, 8, -1, 0, -1);
        chk("pal_frame_lines", frame_lines, 312);
        chk("pal_detect", pal_detect, 1);
        chk("pal_unlocked", locked, 0);
        frame(16, 262, 5, 250, 6, 8, -1, 0, -1);
        chk("back_frame_lines", frame_lines, 262);
        chk("back_pal", pal_detect, 0);
        chk("back_locked", locked, 0);

        // wide lines: reset mid-line, relock, x saturation
        wcount = 0;
        frame(580, 6, 1, 4, 16, 528, -1, 0, 2);
        for (int f = 0; f < 3; f++) frame(580, 6, 1, 4, 16, 528, -1, 0, -1);
        chk("relock_no_writes", wcount, 0);
        wcount = 0;
        frame(580, 6, 1, 4, 16, 528, -1, 0, -1);
        chk("wide_writes", wcount, 4 * 512);
        chk("wide_first_x", fx, 0);
        chk("wide_first_y", fy, 0);
        chk("wide_last_x", ox, 511);
        chk("wide_last_y", oy, 3);
        wcount = 0;
        frame(580, 6, 1, 4, 16, 528, 2, 550, -1);
        chk("short_writes", wcount, 2 * 512);
        chk("short_unlocked", locked, 0);
        wcount = 0;
        frame(580, 6, 1, 4, 16, 528, -1, 0, -1);
        chk("short_relock_pending", wcount, 0);
        frame(580, 6, 1, 4, 16, 528, -1, 0, -1);
        chk("short_relock_writes", wcount, 4 * 512);
        chk("short_relocked", locked, 1);

        // sync_h stuck low
        for (int i = 0; i < 1100; i++) sample(0, 0, 1, 0, 0);
        chk("hstuck_unlocked", locked, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
